md_phase_scheduler: RTL and testbench
=====================================

Name: md_phase_scheduler

Overview:
- Top-level timestep sequencer for the MD core.
- Each iteration it launches force evaluation across all cells, waits for every cell's done event, then waits a fixed pipeline-drain interval.
- It then launches motion update on motion_update_control, waits for its done event, and repeats for a programmed number of iterations.
- It is the only source of motion_update_start and of the force-evaluation start and force-cache clear pulses.

Parameters:
- NUM_CELLS, 64, number of home cells, which is also the width of the per-cell force-done vector.
- ITER_WIDTH, 16, width of the iteration limit and the iteration counter.
- DRAIN_CYCLES, 32, number of cycles spent in DRAIN after all cells report done. Legal range is 1..2^DRAIN_WIDTH-1.
- DRAIN_WIDTH, 6, width of the drain counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run. Sampled only in IDLE or DONE.
- abort  in  1  forces return to IDLE from any state.
- num_iterations  in  ITER_WIDTH  iteration limit. Latched on an accepted start.
- in_force_eval_done  in  NUM_CELLS  per-cell force-evaluation done level.
- in_motion_update_done  in  1  done level from motion_update_control.
- out_force_cache_clear  out  1  clear pulse to all force caches.
- out_force_eval_start  out  1  one-cycle start pulse to the force pipelines.
- out_motion_update_start  out  1  one-cycle start pulse to motion_update_control.
- out_iteration_count  out  ITER_WIDTH  number of completed iterations.
- out_phase  out  3  current state encoding.
- out_busy  out  1  high in every state except IDLE and DONE.
- out_all_done  out  1  high while in DONE.

Behaviour:
- State encoding: IDLE=0, FE_START=1, FE_WAIT=2, DRAIN=3, MU_START=4, MU_WAIT=5, ITER_CHECK=6, DONE=7.
- All outputs are Moore, registered, and decoded from state; out_phase equals the state encoding.
- Reset (rst=0, asynchronous):
  - state goes to IDLE.
  - iteration counter, latched limit, done mask, edge registers and drain counter all clear to 0.
  - All outputs are 0 (out_phase=0).
- Edge detection:
  - prev_fe[NUM_CELLS] and prev_mu are registered copies of the done inputs, updated every cycle.
  - A done event is a rising edge: input=1 and prev=0.
  - Done levels already high when a phase starts do not count.
- IDLE / DONE:
  - start=1 latches num_iterations, clears out_iteration_count and moves to FE_START.
  - Exception: if the latched value is 0, go to DONE instead.
  - start=0 holds the current state.
- FE_START (exactly 1 cycle):
  - out_force_eval_start=1 and out_force_cache_clear=1.
  - done_mask is cleared to 0.
  - Next state is FE_WAIT.
- FE_WAIT:
  - done_mask[i] is set on a rising edge of in_force_eval_done[i], sticky.
  - When done_mask, OR'd with this cycle's rising-edge vector, is all ones, load the drain counter with DRAIN_CYCLES-1 and go to DRAIN.
  - The last cell's edge and the transition happen in the same cycle.
- DRAIN:
  - Decrement the drain counter each cycle.
  - In the cycle the counter equals 0, go to MU_START. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
- MU_START (exactly 1 cycle):
  - out_motion_update_start=1.
  - Next state is MU_WAIT.
- MU_WAIT:
  - A rising edge of in_motion_update_done moves to ITER_CHECK.
  - A done level already high on entry is ignored until it falls and rises again.
- ITER_CHECK (1 cycle):
  - out_iteration_count increments.
  - If the incremented value equals the latched limit, go to DONE; otherwise go to FE_START.
- out_iteration_count:
  - Holds its value in DONE until the next accepted start.
  - It never wraps, because the limit is at most 2^ITER_WIDTH-1.
- start in any busy state is ignored; the latched limit is unchanged.
- abort=1 (synchronous):
  - Next state is IDLE; done_mask and drain counter clear.
  - out_iteration_count retains its value.
  - No out_all_done is produced.
  - abort takes priority over start and over every transition in the same cycle.
- Asynchronous reset during any phase returns to IDLE immediately. No start pulse is emitted afterwards until a new start.
- Start-to-force-pulse latency: start sampled at edge N gives out_force_eval_start=1 in cycle N+1.
- Minimum iteration length is 1 (FE_START) + 1 (FE_WAIT) + DRAIN_CYCLES + 1 (MU_START) + 1 (MU_WAIT) + 1 (ITER_CHECK) cycles.

Test Plan:
- Single iteration: num_iterations=1, start at cycle 0; raise all 64 force-done bits at cycle 5; pulse motion-done 10 cycles after out_motion_update_start.
  - out_force_eval_start=1 and out_force_cache_clear=1 at cycle 1 only.
  - DRAIN lasts 32 cycles.
  - out_motion_update_start is high for 1 cycle.
  - After ITER_CHECK: out_iteration_count=1, out_all_done=1, out_phase=7.
- Staggered cell done: bits 0..62 rise at cycles 3..65 and fall again; bit 63 rises at cycle 100.
  - FE_WAIT exits at cycle 100; DRAIN is entered at cycle 101.
- Stale levels:
  - in_force_eval_done=all ones held from before start produces no exit until each bit falls and rises again.
  - in_motion_update_done held high on MU_WAIT entry is ignored.
- Multi-iteration: num_iterations=3, with done responses delayed a random 1..20 cycles.
  - Exactly 3 out_force_eval_start pulses and 3 out_motion_update_start pulses.
  - Final out_iteration_count=3.
  - start pulses issued mid-run are ignored.
- Zero iterations and restart:
  - num_iterations=0 with start goes IDLE->DONE; no start pulses; out_iteration_count=0.
  - A second start with num_iterations=2 from DONE completes 2 iterations.
- Abort and reset:
  - abort in DRAIN with count=1 gives IDLE next cycle, no out_motion_update_start, count stays 1.
  - rst=0 asserted in MU_WAIT clears all outputs to 0 asynchronously, with no clock edge needed.

Source files
------------

// File: rtl/md_phase_scheduler.sv
// md_phase_scheduler: timestep sequencer for the MD core.
// Runs force eval -> drain -> motion update for a programmed iteration count.
//
// Ports:
//   clk, rst (async, active-low)     clock / reset
//   start, abort                     run request / forced return to IDLE
//   num_iterations                   iteration limit, latched on accepted start
//   in_force_eval_done               per-cell force-eval done levels
//   in_motion_update_done            motion-update done level
//   out_force_cache_clear            clear pulse to force caches
//   out_force_eval_start             force pipeline start pulse
//   out_motion_update_start          motion update start pulse
//   out_iteration_count              completed iterations
//   out_phase                        current state encoding
//   out_busy, out_all_done           status
module md_phase_scheduler #(
    parameter int NUM_CELLS    = 64,
    parameter int ITER_WIDTH   = 16,
    parameter int DRAIN_CYCLES = 32,
    parameter int DRAIN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ITER_WIDTH-1:0] num_iterations,
    input  logic [NUM_CELLS-1:0]  in_force_eval_done,
    input  logic                  in_motion_update_done,
    output logic                  out_force_cache_clear,
    output logic                  out_force_eval_start,
    output logic                  out_motion_update_start,
    output logic [ITER_WIDTH-1:0] out_iteration_count,
    output logic [2:0]            out_phase,
    output logic                  out_busy,
    output logic                  out_all_done
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FE_START   = 3'd1;
    localparam logic [2:0] S_FE_WAIT    = 3'd2;
    localparam logic [2:0] S_DRAIN      = 3'd3;
    localparam logic [2:0] S_MU_START   = 3'd4;
    localparam logic [2:0] S_MU_WAIT    = 3'd5;
    localparam logic [2:0] S_ITER_CHECK = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    localparam logic [DRAIN_WIDTH-1:0] DRAIN_LOAD =
        DRAIN_WIDTH'(DRAIN_CYCLES - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [ITER_WIDTH-1:0] r_iter;
    logic [ITER_WIDTH-1:0] r_limit;
    logic [ITER_WIDTH-1:0] w_iter_inc;
    logic [NUM_CELLS-1:0]  r_mask;
    logic [NUM_CELLS-1:0]  r_prev_fe;
    logic [NUM_CELLS-1:0]  w_fe_rise;
    logic                  r_prev_mu;
    logic                  w_mu_rise;
    logic                  w_fe_all;
    logic [DRAIN_WIDTH-1:0] r_drain;

    // Only rising edges count, so levels left high from earlier are ignored.
    assign w_fe_rise  = in_force_eval_done & ~r_prev_fe;
    assign w_mu_rise  = in_motion_update_done & ~r_prev_mu;
    // The last cell's edge completes the mask in the same cycle it arrives.
    assign w_fe_all   = &(r_mask | w_fe_rise);
    assign w_iter_inc = r_iter + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = (num_iterations == '0) ? S_DONE : S_FE_START;
                end
            end
            S_FE_START: w_next = S_FE_WAIT;
            S_FE_WAIT: begin
                if (w_fe_all) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == '0) w_next = S_MU_START;
            end
            S_MU_START: w_next = S_MU_WAIT;
            S_MU_WAIT: begin
                if (w_mu_rise) w_next = S_ITER_CHECK;
            end
            S_ITER_CHECK: begin
                w_next = (w_iter_inc == r_limit) ? S_DONE : S_FE_START;
            end
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_iter    <= '0;
            r_limit   <= '0;
            r_mask    <= '0;
            r_prev_fe <= '0;
            r_prev_mu <= 1'b0;
            r_drain   <= '0;
        end else begin
            r_state   <= w_next;
            r_prev_fe <= in_force_eval_done;
            r_prev_mu <= in_motion_update_done;
            if (abort) begin
                r_mask  <= '0;
                r_drain <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            r_limit <= num_iterations;
                            r_iter  <= '0;
                        end
                    end
                    S_FE_START: r_mask <= '0;
                    S_FE_WAIT: begin
                        r_mask <= r_mask | w_fe_rise;
                        if (w_fe_all) r_drain <= DRAIN_LOAD;
                    end
                    S_DRAIN: begin
                        if (r_drain != '0) r_drain <= r_drain - 1'b1;
                    end
                    S_ITER_CHECK: r_iter <= w_iter_inc;
                    default: ;
                endcase
            end
        end
    end

    // Moore outputs decoded straight from the state register.
    assign out_force_cache_clear   = (r_state == S_FE_START);
    assign out_force_eval_start    = (r_state == S_FE_START);
    assign out_motion_update_start = (r_state == S_MU_START);
    assign out_iteration_count     = r_iter;
    assign out_phase               = r_state;
    assign out_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign out_all_done = (r_state == S_DONE);

endmodule

// File: tb/tb_md_phase_scheduler.sv
// tb_md_phase_scheduler: directed self-checking bench for md_phase_scheduler.
// Steps are driven 1ns after each rising edge and checked at the same point.
module tb_md_phase_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_iterations = '0;
    logic [63:0] fe_done = '0;
    logic        mu_done = 1'b0;
    logic        fc_clear;
    logic        fe_start;
    logic        mu_start;
    logic [15:0] iter_cnt;
    logic [2:0]  phase;
    logic        busy;
    logic        all_done;

    int total = 0;
    int bad = 0;
    int n_fe = 0;
    int n_mu = 0;
    int n_drain;

    md_phase_scheduler dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .abort                   (abort),
        .num_iterations          (num_iterations),
        .in_force_eval_done      (fe_done),
        .in_motion_update_done   (mu_done),
        .out_force_cache_clear   (fc_clear),
        .out_force_eval_start    (fe_start),
        .out_motion_update_start (mu_start),
        .out_iteration_count     (iter_cnt),
        .out_phase               (phase),
        .out_busy                (busy),
        .out_all_done            (all_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fe_start) n_fe++;
        if (mu_start) n_mu++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_phase(input logic [2:0] p, input int bound);
        int n = 0;
        while (phase !== p && n < bound) begin
            tick();
            n++;
        end
        chk("wait_phase", 32'(phase), 32'(p));
    endtask

    task automatic go(input logic [15:0] n);
        num_iterations = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_iter(input int dfe, input int dmu);
        wait_phase(3'd2, 20);
        repeat (dfe) tick();
        fe_done = '1;
        wait_phase(3'd5, 200);
        fe_done = '0;
        repeat (dmu) tick();
        mu_done = 1'b1;
        wait_phase(3'd6, 10);
        mu_done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_phase", 32'(phase), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(iter_cnt), 0);
        chk("rst_pulses", {29'd0, fe_start, fc_clear, mu_start}, 0);
        rst = 1'b1;
        tick();

        // Single iteration
        go(16'd1);
        chk("s1_fe_start", 32'(fe_start), 1);
        chk("s1_clear", 32'(fc_clear), 1);
        chk("s1_phase_fes", 32'(phase), 1);
        tick();
        chk("s1_fe_start_off", 32'(fe_start), 0);
        chk("s1_phase_few", 32'(phase), 2);
        repeat (3) tick();
        fe_done = '1;
        tick();
        chk("s1_drain_entry", 32'(phase), 3);
        n_drain = 0;
        while (phase === 3'd3 && n_drain < 100) begin
            n_drain++;
            tick();
        end
        chk("s1_drain_len", 32'(n_drain), 32);
        chk("s1_mu_start", 32'(mu_start), 1);
        tick();
        chk("s1_mu_start_off", 32'(mu_start), 0);
        fe_done = '0;
        repeat (9) tick();
        chk("s1_mu_wait", 32'(phase), 5);
        mu_done = 1'b1;
        tick();
        chk("s1_iter_check", 32'(phase), 6);
        mu_done = 1'b0;
        tick();
        chk("s1_count", 32'(iter_cnt), 1);
        chk("s1_all_done", 32'(all_done), 1);
        chk("s1_phase_done", 32'(phase), 7);
        chk("s1_busy", 32'(busy), 0);

        // Staggered cell done
        go(16'd1);
        tick();
        for (int i = 0; i < 63; i++) begin
            fe_done = 64'd1 << i;
            tick();
        end
        fe_done = '0;
        repeat (5) tick();
        chk("stag_hold", 32'(phase), 2);
        fe_done[63] = 1'b1;
        tick();
        chk("stag_exit", 32'(phase), 3);
        fe_done = '0;
        wait_phase(3'd5, 100);
        mu_done = 1'b1;
        tick();
        mu_done = 1'b0;
        wait_phase(3'd7, 5);

        // Stale levels
        fe_done = '1;
        repeat (2) tick();
        go(16'd1);
        tick();
        repeat (5) tick();
        chk("stale_fe_hold", 32'(phase), 2);
        fe_done = '0;
        tick();
        chk("stale_fe_low", 32'(phase), 2);
        fe_done = '1;
        tick();
        chk("stale_fe_exit", 32'(phase), 3);
        mu_done = 1'b1;
        wait_phase(3'd5, 100);
        repeat (5) tick();
        chk("stale_mu_hold", 32'(phase), 5);
        mu_done = 1'b0;
        tick();
        chk("stale_mu_low", 32'(phase), 5);
        mu_done = 1'b1;
        tick();
        chk("stale_mu_exit", 32'(phase), 6);
        mu_done = 1'b0;
        fe_done = '0;
        wait_phase(3'd7, 5);

        // Multi-iteration with random delays, mid-run start ignored
        n_fe = 0;
        n_mu = 0;
        go(16'd3);
        for (int it = 0; it < 3; it++) begin
            if (it == 1) begin
                num_iterations = 16'd9;
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            run_iter($urandom_range(1, 20), $urandom_range(1, 20));
        end
        tick();
        chk("multi_phase", 32'(phase), 7);
        chk("multi_count", 32'(iter_cnt), 3);
        chk("multi_fe_pulses", 32'(n_fe), 3);
        chk("multi_mu_pulses", 32'(n_mu), 3);

        // Zero iterations, then restart from DONE
        n_fe = 0;
        n_mu = 0;
        go(16'd0);
        chk("zero_phase", 32'(phase), 7);
        chk("zero_count", 32'(iter_cnt), 0);
        tick();
        chk("zero_pulses", 32'(n_fe + n_mu), 0);
        go(16'd2);
        run_iter(2, 3);
        run_iter(4, 1);
        tick();
        chk("restart_phase", 32'(phase), 7);
        chk("restart_count", 32'(iter_cnt), 2);
        chk("restart_fe_pulses", 32'(n_fe), 2);

        // Abort in DRAIN with count=1
        n_mu = 0;
        go(16'd2);
        run_iter(1, 1);
        wait_phase(3'd2, 10);
        fe_done = '1;
        tick();
        chk("abort_in_drain", 32'(phase), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        fe_done = '0;
        chk("abort_phase", 32'(phase), 0);
        chk("abort_count", 32'(iter_cnt), 1);
        chk("abort_all_done", 32'(all_done), 0);
        repeat (40) tick();
        chk("abort_idle_hold", 32'(phase), 0);
        chk("abort_mu_pulses", 32'(n_mu), 1);

        // Async reset in MU_WAIT
        go(16'd1);
        wait_phase(3'd2, 5);
        fe_done = '1;
        wait_phase(3'd5, 100);
        fe_done = '0;
        #2 rst = 1'b0;
        #1;
        chk("arst_phase", 32'(phase), 0);
        chk("arst_count", 32'(iter_cnt), 0);
        chk("arst_status", {30'd0, busy, all_done}, 0);
        chk("arst_pulses", {29'd0, fe_start, fc_clear, mu_start}, 0);
        n_fe = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) tick();
        chk("arst_no_pulse", 32'(n_fe), 0);
        chk("arst_idle", 32'(phase), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
